// File: rtl/miss_id_tracker.sv
// Outstanding cache-miss ID tracker: allocates IDs from an external free-ID FIFO,
// holds per-ID metadata while a miss is in flight, and returns it through a registered response port.
module miss_id_tracker #(
    parameter int NUM_IDS    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_IDS),
    parameter int META_WIDTH = 16,
    parameter int CNT_WIDTH  = $clog2(NUM_IDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic [META_WIDTH-1:0] req_meta_i,
    output logic                  req_ready_o,
    output logic [ID_WIDTH-1:0]   req_id_o,
    input  logic [ID_WIDTH-1:0]   free_id_i,
    input  logic                  free_empty_i,
    output logic                  free_pop_o,
    output logic [ID_WIDTH-1:0]   free_id_o,
    output logic                  free_push_o,
    input  logic                  free_full_i,
    input  logic                  rsp_valid_i,
    input  logic [ID_WIDTH-1:0]   rsp_id_i,
    output logic                  rsp_ready_o,
    output logic                  rsp_valid_o,
    output logic [ID_WIDTH-1:0]   rsp_id_o,
    output logic [META_WIDTH-1:0] rsp_meta_o,
    input  logic                  rsp_ready_i,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
    output logic                  err_o
);

    logic [NUM_IDS-1:0]    r_valid;
    logic [META_WIDTH-1:0] r_meta [NUM_IDS];
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_out_valid;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic [META_WIDTH-1:0] r_out_meta;
    logic                  r_err;

    logic                  w_alloc;
    logic                  w_alloc_dup;
    logic                  w_rsp_acc;
    logic                  w_rsp_hit;
    logic                  w_rsp_miss;
    logic                  w_push_lost;
    logic [NUM_IDS-1:0]    w_valid_nxt;

    assign w_alloc     = req_valid_i & ~free_empty_i;
    assign w_alloc_dup = w_alloc & r_valid[free_id_i];
    assign w_rsp_acc   = rsp_valid_i & rsp_ready_o;
    assign w_rsp_hit   = w_rsp_acc & r_valid[rsp_id_i];
    assign w_rsp_miss  = w_rsp_acc & ~r_valid[rsp_id_i];
    assign w_push_lost = w_rsp_hit & free_full_i;

    assign req_ready_o   = ~free_empty_i;
    assign req_id_o      = free_id_i;
    assign free_pop_o    = w_alloc;
    assign free_id_o     = rsp_id_i;
    assign free_push_o   = w_rsp_hit & ~free_full_i;
    assign rsp_ready_o   = ~r_out_valid | rsp_ready_i;
    assign rsp_valid_o   = r_out_valid;
    assign rsp_id_o      = r_out_id;
    assign rsp_meta_o    = r_out_meta;
    assign outstanding_o = r_cnt;
    assign err_o         = r_err;

    // Release is applied before allocation; the two only collide on the same ID in illegal use.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_rsp_hit) begin
            w_valid_nxt[rsp_id_i] = 1'b0;
        end
        if (w_alloc) begin
            w_valid_nxt[free_id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_IDS; i++) begin
                r_meta[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            if (w_alloc) begin
                r_meta[free_id_i] <= req_meta_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_alloc && !w_rsp_hit) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end else if (!w_alloc && w_rsp_hit) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    // The output register keeps a copy of the metadata, so reallocating the ID cannot disturb it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_meta  <= '0;
        end else if (w_rsp_hit) begin
            r_out_valid <= 1'b1;
            r_out_id    <= rsp_id_i;
            r_out_meta  <= r_meta[rsp_id_i];
        end else if (rsp_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_alloc_dup || w_rsp_miss || w_push_lost) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_miss_id_tracker.sv
// Directed bench for miss_id_tracker; the bench itself plays the free-ID FIFO.
module tb_miss_id_tracker;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic [15:0] req_meta_i;
  logic        req_ready_o;
  logic [1:0]  req_id_o;
  logic [1:0]  free_id_i;
  logic        free_empty_i;
  logic        free_pop_o;
  logic [1:0]  free_id_o;
  logic        free_push_o;
  logic        free_full_i;
  logic        rsp_valid_i;
  logic [1:0]  rsp_id_i;
  logic        rsp_ready_o;
  logic        rsp_valid_o;
  logic [1:0]  rsp_id_o;
  logic [15:0] rsp_meta_o;
  logic        rsp_ready_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  miss_id_tracker #(.NUM_IDS(4), .META_WIDTH(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_meta_i   (req_meta_i),
    .req_ready_o  (req_ready_o),
    .req_id_o     (req_id_o),
    .free_id_i    (free_id_i),
    .free_empty_i (free_empty_i),
    .free_pop_o   (free_pop_o),
    .free_id_o    (free_id_o),
    .free_push_o  (free_push_o),
    .free_full_i  (free_full_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_id_i     (rsp_id_i),
    .rsp_ready_o  (rsp_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_meta_o   (rsp_meta_o),
    .rsp_ready_i  (rsp_ready_i),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_meta_i   = 16'h0;
    free_id_i    = 2'd0;
    free_empty_i = 1'b0;
    free_full_i  = 1'b1;
    rsp_valid_i  = 1'b0;
    rsp_id_i     = 2'd0;
    rsp_ready_i  = 1'b1;
    #12;
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_id", rsp_id_o, 2'd0);
    chk("rst_rsp_meta", rsp_meta_o, 16'h0);
    chk("rst_outstanding", outstanding_o, 3'd0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rsp_ready", rsp_ready_o, 1'b1);
    rst_ni = 1'b1;
    step();

    // Fill: allocate IDs 0..3
    for (int k = 0; k < 4; k++) begin
      req_valid_i = 1'b1;
      free_id_i   = 2'(k);
      req_meta_i  = 16'hA0 + 16'(k);
      free_full_i = (k == 0);
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
        errors++;
        $error("FAIL alloc_ready observed=%0h expected=%0h", req_ready_o, 1'b1);
      end
      checks++;
      if (req_id_o !== 2'(k)) begin
        errors++;
        $error("FAIL alloc_id observed=%0h expected=%0h", req_id_o, 2'(k));
      end
      checks++;
      if (free_pop_o !== 1'b1) begin
        errors++;
        $error("FAIL alloc_pop observed=%0h expected=%0h", free_pop_o, 1'b1);
      end
      step();
    end
    free_full_i  = 1'b0;
    free_empty_i = 1'b1;
    #1;
    chk("empty_ready", req_ready_o, 1'b0);
    chk("empty_pop", free_pop_o, 1'b0);
    chk("full_outstanding", outstanding_o, 3'd4);
    req_valid_i = 1'b0;
    step();
    chk("empty_outstanding", outstanding_o, 3'd4);

    // Release ID 2
    rsp_valid_i = 1'b1;
    rsp_id_i    = 2'd2;
    #1;
    chk("rel2_rsp_ready", rsp_ready_o, 1'b1);
    chk("rel2_push", free_push_o, 1'b1);
    chk("rel2_push_id", free_id_o, 2'd2);
    step();
    rsp_valid_i = 1'b0;
    chk("rel2_valid", rsp_valid_o, 1'b1);
    chk("rel2_id", rsp_id_o, 2'd2);
    chk("rel2_meta", rsp_meta_o, 16'hA2);
    chk("rel2_outstanding", outstanding_o, 3'd3);
    free_empty_i = 1'b0;
    free_id_i    = 2'd2;

    // Backpressure with a second response pending
    rsp_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_id_i    = 2'd0;
    #1;
    chk("bp_rsp_ready", rsp_ready_o, 1'b0);
    chk("bp_push", free_push_o, 1'b0);
    step();
    chk("bp_hold_valid", rsp_valid_o, 1'b1);
    chk("bp_hold_id", rsp_id_o, 2'd2);
    chk("bp_hold_meta", rsp_meta_o, 16'hA2);
    chk("bp_outstanding", outstanding_o, 3'd3);
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_resume_ready", rsp_ready_o, 1'b1);
    chk("bp_resume_push", free_push_o, 1'b1);
    chk("bp_resume_push_id", free_id_o, 2'd0);
    step();
    chk("rel0_id", rsp_id_o, 2'd0);
    chk("rel0_meta", rsp_meta_o, 16'hA0);
    chk("rel0_outstanding", outstanding_o, 3'd2);

    // Release ID 1 so it can be reallocated
    rsp_id_i = 2'd1;
    step();
    rsp_valid_i = 1'b0;
    chk("rel1_meta", rsp_meta_o, 16'hA1);
    chk("rel1_outstanding", outstanding_o, 3'd1);

    // Same-cycle allocation of ID 1 and release of ID 3
    req_valid_i = 1'b1;
    free_id_i   = 2'd1;
    req_meta_i  = 16'hB1;
    rsp_valid_i = 1'b1;
    rsp_id_i    = 2'd3;
    #1;
    chk("both_pop", free_pop_o, 1'b1);
    chk("both_push", free_push_o, 1'b1);
    chk("both_push_id", free_id_o, 2'd3);
    step();
    req_valid_i = 1'b0;
    rsp_valid_i = 1'b0;
    chk("both_outstanding", outstanding_o, 3'd1);
    chk("both_valid1", dut.r_valid[1], 1'b1);
    chk("both_valid3", dut.r_valid[3], 1'b0);
    chk("both_rsp_id", rsp_id_o, 2'd3);
    chk("both_rsp_meta", rsp_meta_o, 16'hA3);

    // Unknown ID 0
    rsp_valid_i = 1'b1;
    rsp_id_i    = 2'd0;
    #1;
    chk("unk_push", free_push_o, 1'b0);
    step();
    rsp_valid_i = 1'b0;
    chk("unk_valid", rsp_valid_o, 1'b0);
    chk("unk_err", err_o, 1'b1);
    chk("unk_outstanding", outstanding_o, 3'd1);
    step();
    chk("err_sticky", err_o, 1'b1);

    // Build 3 outstanding with a response held in the output register
    req_valid_i = 1'b1;
    free_id_i   = 2'd2;
    req_meta_i  = 16'hC2;
    step();
    free_id_i  = 2'd0;
    req_meta_i = 16'hC0;
    step();
    chk("refill_outstanding", outstanding_o, 3'd3);
    free_id_i   = 2'd3;
    req_meta_i  = 16'hC3;
    rsp_valid_i = 1'b1;
    rsp_id_i    = 2'd1;
    step();
    req_valid_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    chk("pre_rst_outstanding", outstanding_o, 3'd3);
    chk("pre_rst_valid", rsp_valid_o, 1'b1);
    chk("pre_rst_meta", rsp_meta_o, 16'hB1);

    // Asynchronous reset mid-cycle
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_outstanding", outstanding_o, 3'd0);
    chk("arst_valid", rsp_valid_o, 1'b0);
    chk("arst_meta", rsp_meta_o, 16'h0);
    chk("arst_err", err_o, 1'b0);
    free_id_i    = 2'd0;
    free_empty_i = 1'b0;
    rsp_ready_i  = 1'b1;
    #1;
    rst_ni      = 1'b1;
    req_valid_i = 1'b1;
    req_meta_i  = 16'hD0;
    #1;
    chk("restart_ready", req_ready_o, 1'b1);
    chk("restart_id", req_id_o, 2'd0);
    step();
    req_valid_i = 1'b0;
    chk("restart_outstanding", outstanding_o, 3'd1);
    chk("restart_err", err_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/miss_id_tracker.md
# miss_id_tracker

Tracks outstanding cache-miss transactions by ID. It draws free IDs from an upstream free-ID FIFO that holds every ID at reset, and stores per-ID metadata while a miss is in flight. When a response arrives it returns the metadata on a registered response port and pushes the ID back into the free-ID FIFO. It sits directly between that free-list FIFO and the miss request/response paths of the cache subsystem.

## Interface
Parameters:
- NUM_IDS, 4, number of transaction IDs; must be ≥2 and equal to the free-list FIFO depth.
- ID_WIDTH, $clog2(NUM_IDS), width of an ID (derived, do not override).
- META_WIDTH, 16, per-transaction metadata width.
- CNT_WIDTH, $clog2(NUM_IDS+1), outstanding-counter width (derived, do not override).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  new miss request.
- req_meta_i  in  META_WIDTH  metadata to store for the request.
- req_ready_o  out  1  request accepted this cycle if req_valid_i is also high.
- req_id_o  out  ID_WIDTH  ID assigned to the request; valid while req_ready_o is high.
- free_id_i  in  ID_WIDTH  head of the free-ID FIFO.
- free_empty_i  in  1  free-ID FIFO is empty.
- free_pop_o  out  1  pop the free-ID FIFO.
- free_id_o  out  ID_WIDTH  ID returned to the free-ID FIFO.
- free_push_o  out  1  push free_id_o into the free-ID FIFO.
- free_full_i  in  1  free-ID FIFO is full.
- rsp_valid_i  in  1  incoming response.
- rsp_id_i  in  ID_WIDTH  ID of the incoming response.
- rsp_ready_o  out  1  incoming response accepted.
- rsp_valid_o  out  1  registered response valid.
- rsp_id_o  out  ID_WIDTH  registered response ID.
- rsp_meta_o  out  META_WIDTH  metadata stored for that ID.
- rsp_ready_i  in  1  downstream consumes the registered response.
- outstanding_o  out  CNT_WIDTH  number of IDs currently allocated.
- err_o  out  1  sticky protocol error.

## Operation
- State:
  - valid_q[NUM_IDS] and meta_q[NUM_IDS] form the per-ID table.
  - cnt_q is the outstanding count.
  - The output register holds out_valid_q, out_id_q and out_meta_q.
  - err_q is the sticky error flag.
- Allocation:
  - req_ready_o = ~free_empty_i. req_id_o = free_id_i, combinationally.
  - On req_valid_i & req_ready_o: free_pop_o=1, valid_q[free_id_i]←1, meta_q[free_id_i]←req_meta_i.
  - If valid_q[free_id_i] is already 1: err_q←1, and the entry is overwritten anyway.
- Response accept:
  - rsp_ready_o = ~out_valid_q | rsp_ready_i.
  - On rsp_valid_i & rsp_ready_o with valid_q[rsp_id_i]=1:
    - out_valid_q←1, out_id_q←rsp_id_i, out_meta_q←meta_q[rsp_id_i];
    - valid_q[rsp_id_i]←0;
    - free_push_o=1 with free_id_o=rsp_id_i in the same cycle.
  - If free_full_i is high at that point: err_q←1 and no push.
- Unknown ID: a response accepted with valid_q[rsp_id_i]=0 is dropped, with no output, no push and no counter change; err_q←1.
- Output drain: if rsp_ready_i & out_valid_q and no new accept in the same cycle, out_valid_q←0.
- Counter:
  - cnt_q +1 on allocation, −1 on a valid release, unchanged when both happen in one cycle.
  - Width CNT_WIDTH; never wraps in legal operation.
- outstanding_o = cnt_q.
- err_o = err_q; it is cleared only by reset.
- A same-cycle allocate and release always involve different IDs in legal operation.
- A released ID may be reallocated from the FIFO on a later cycle while its response is still in the output register. out_meta_q is a copy, so it is unaffected.

## Timing
- Reset values:
  - valid_q=0, meta_q=0, cnt_q=0, err_q=0, out_valid_q=0, out_id_q=0, out_meta_q=0.
  - Hence rsp_valid_o=0, rsp_id_o=0, rsp_meta_o=0, outstanding_o=0, err_o=0.
  - rsp_ready_o=1.
  - req_ready_o, req_id_o, free_pop_o, free_push_o and free_id_o follow their combinational definitions.
- Allocation has zero latency: the ID is presented in the handshake cycle, and the table updates at the next edge.
- Response has one-cycle latency: accepted in cycle N, visible on rsp_*_o in cycle N+1. Throughput is one response per cycle while rsp_ready_i=1.
- A response for an ID allocated in cycle N is legal from cycle N+1.
- Reset asserted mid-operation clears all state immediately (asynchronously). The free-ID FIFO must be reset on the same rst_ni so that it is refilled with all IDs.
- rsp_valid_o, rsp_id_o and rsp_meta_o remain stable while rsp_valid_o=1 & rsp_ready_i=0.

## Test plan
- Reset, then FIFO holds IDs 0..3; four requests with meta 0xA0..0xA3 → req_id_o 0,1,2,3; outstanding_o=4; req_ready_o=0 once free_empty_i=1.
- Response for ID 2 with rsp_ready_i=1 → next cycle rsp_valid_o=1, rsp_id_o=2, rsp_meta_o=0xA2; free_push_o=1 with free_id_o=2 in the accept cycle; outstanding_o=3.
- rsp_ready_i=0 with the output full, and a second response pending → rsp_ready_o=0; outputs held; the second response is accepted in the cycle rsp_ready_i returns to 1.
- Same-cycle allocation of ID 1 and release of ID 3 → outstanding_o unchanged; valid_q[1]=1, valid_q[3]=0.
- Response with ID 0 while ID 0 is not outstanding → no rsp_valid_o and no push; err_o=1 and it stays set until reset.
- Async reset asserted with 3 IDs outstanding and rsp_valid_o=1 → outstanding_o=0, rsp_valid_o=0 and err_o=0 immediately; after release, allocation restarts from ID 0.
